// File: rtl/tile_renderer.sv
// Tile renderer: turns raster positions into tile-map reads and outputs coloured pixels.
// The pipeline has 3 stages, and each pixel carries a valid flag through it.
// A frame-counted blink phase drives the bomb tiles.
// Optional build macro: GRID_LINES_EN. When defined, the first row and first column
// of pixels in every tile are drawn dark grey, between player and tile priority.
module tile_renderer #(
    parameter int NUM_COL      = 19,
    parameter int NUM_ROW      = 11,
    parameter int DATA_WIDTH   = 4,
    parameter int TILE_SHIFT   = 6,
    parameter int MAP_X0       = 32,
    parameter int MAP_Y0       = 48,
    parameter int PLAYER_SIZE  = 48,
    parameter int BLINK_FRAMES = 16,
    parameter int ADDR_W       = $clog2(NUM_ROW*NUM_COL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [10:0]           draw_x,
    input  logic [9:0]            draw_y,
    input  logic [11:0]           i_rgb,
    input  logic [10:0]           blkpos_x,
    input  logic [9:0]            blkpos_y,
    output logic [ADDR_W-1:0]     map_addr,
    input  logic [DATA_WIDTH-1:0] map_rd_data,
    output logic                  o_valid,
    output logic [11:0]           o_rgb,
    output logic                  o_in_map
);

    // Map bounds and player size, widened by one bit so the sums cannot wrap
    localparam logic [11:0] X_LO = 12'(MAP_X0);
    localparam logic [11:0] X_HI = 12'(MAP_X0 + (NUM_COL << TILE_SHIFT));
    localparam logic [10:0] Y_LO = 11'(MAP_Y0);
    localparam logic [10:0] Y_HI = 11'(MAP_Y0 + (NUM_ROW << TILE_SHIFT));
    localparam logic [11:0] PX   = 12'(PLAYER_SIZE);
    localparam logic [10:0] PY   = 11'(PLAYER_SIZE);
    localparam int          FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [11:0]       px_ext;
    logic [10:0]       py_ext;
    logic [11:0]       dx;
    logic [10:0]       dy;
    logic              in_map;
    logic              player_hit;
    logic [ADDR_W-1:0] tile_addr;

    logic [FC_W-1:0]   frame_cnt;
    logic              blink_phase;
    logic              frame_start;

    logic              s1_valid, s1_in_map, s1_hit, s1_phase;
    logic [11:0]       s1_rgb;
    logic              s2_valid, s2_in_map, s2_hit, s2_phase;
    logic [11:0]       s2_rgb;
    logic [11:0]       pix_rgb;

`ifdef GRID_LINES_EN
    logic              on_grid;
    logic              s1_grid, s2_grid;
`endif

    // Stage-1 decode: map membership, tile address and player box test
    always_comb begin
        px_ext     = {1'b0, draw_x};
        py_ext     = {1'b0, draw_y};
        dx         = px_ext - X_LO;
        dy         = py_ext - Y_LO;
        in_map     = (px_ext >= X_LO) && (px_ext < X_HI) &&
                     (py_ext >= Y_LO) && (py_ext < Y_HI);
        player_hit = (draw_x >= blkpos_x) && (px_ext < ({1'b0, blkpos_x} + PX)) &&
                     (draw_y >= blkpos_y) && (py_ext < ({1'b0, blkpos_y} + PY));
        tile_addr  = ADDR_W'(dy >> TILE_SHIFT) * ADDR_W'(NUM_COL) + ADDR_W'(dx >> TILE_SHIFT);
    end

`ifdef GRID_LINES_EN
    // A pixel is on a grid line when its offset within the tile is zero on either axis
    always_comb begin
        on_grid = in_map && ((dx[TILE_SHIFT-1:0] == '0) || (dy[TILE_SHIFT-1:0] == '0));
    end
`endif

    assign frame_start = i_valid && (draw_x == 11'd0) && (draw_y == 10'd0);

    // Frame counter: the blink phase flips once every BLINK_FRAMES frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Stage 1: issue the map read and latch the sideband; the address only moves on valid pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            map_addr  <= '0;
            s1_in_map <= 1'b0;
            s1_hit    <= 1'b0;
            s1_rgb    <= '0;
            s1_phase  <= 1'b0;
`ifdef GRID_LINES_EN
            s1_grid   <= 1'b0;
`endif
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                map_addr  <= in_map ? tile_addr : '0;
                s1_in_map <= in_map;
                s1_hit    <= player_hit;
                s1_rgb    <= i_rgb;
                s1_phase  <= blink_phase;
`ifdef GRID_LINES_EN
                s1_grid   <= on_grid;
`endif
            end
        end
    end

    // Stage 2: the sideband waits here while the map memory returns the tile state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_in_map <= 1'b0;
            s2_hit    <= 1'b0;
            s2_rgb    <= '0;
            s2_phase  <= 1'b0;
`ifdef GRID_LINES_EN
            s2_grid   <= 1'b0;
`endif
        end else begin
            s2_valid  <= s1_valid;
            s2_in_map <= s1_in_map;
            s2_hit    <= s1_hit;
            s2_rgb    <= s1_rgb;
            s2_phase  <= s1_phase;
`ifdef GRID_LINES_EN
            s2_grid   <= s1_grid;
`endif
        end
    end

    // Colour selection by priority: player, then off-map, then grid, then tile palette
    always_comb begin
        pix_rgb = 12'hF0F;
        if (s2_hit) begin
            pix_rgb = 12'h00F;
        end else if (!s2_in_map) begin
            pix_rgb = s2_rgb;
`ifdef GRID_LINES_EN
        end else if (s2_grid) begin
            pix_rgb = 12'h222;
`endif
        end else if (map_rd_data == DATA_WIDTH'(0)) begin
            pix_rgb = s2_rgb;
        end else if (map_rd_data == DATA_WIDTH'(1)) begin
            pix_rgb = 12'h888;
        end else if (map_rd_data == DATA_WIDTH'(2)) begin
            pix_rgb = 12'hA52;
        end else if (map_rd_data == DATA_WIDTH'(3)) begin
            pix_rgb = s2_phase ? 12'hF00 : 12'h000;
        end
    end

    // Stage 3: output register; colour and map flag hold between valid pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid  <= 1'b0;
            o_rgb    <= '0;
            o_in_map <= 1'b0;
        end else begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_rgb    <= pix_rgb;
                o_in_map <= s2_in_map;
            end
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// Self-checking bench for tile_renderer. It uses directed vectors and a few multi-cycle sequences.
// The map memory model is a 1-cycle synchronous read. BLINK_FRAMES is set to 2.
module tb_tile_renderer;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [11:0] rgb;
        logic [10:0] bx;
        logic [9:0]  by;
        logic [7:0]  exp_addr;
        logic [11:0] exp_rgb;
        logic        exp_in_map;
        logic        on_grid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [10:0] draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic [11:0] i_rgb = '0;
    logic [10:0] blkpos_x = 11'd1500;
    logic [9:0]  blkpos_y = 10'd900;
    logic [7:0]  map_addr;
    logic [3:0]  map_rd_data;
    logic        o_valid;
    logic [11:0] o_rgb;
    logic        o_in_map;

    logic [3:0]  mem [0:255];
    logic [2:0]  hist;
    int          tests_run = 0;
    int          tests_failed = 0;

    tile_renderer #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .draw_x(draw_x), .draw_y(draw_y),
        .i_rgb(i_rgb), .blkpos_x(blkpos_x), .blkpos_y(blkpos_y), .map_addr(map_addr),
        .map_rd_data(map_rd_data), .o_valid(o_valid), .o_rgb(o_rgb), .o_in_map(o_in_map)
    );

    always #5 clk = ~clk;

    // Synchronous map memory with one cycle of read latency
    always_ff @(posedge clk) map_rd_data <= mem[map_addr];

    // Reference delay line: o_valid should follow i_valid by three edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= '0;
        else        hist <= {hist[1:0], i_valid};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] expRgb(input vec_t v);
`ifdef GRID_LINES_EN
        if (v.on_grid && v.exp_in_map && v.exp_rgb != 12'h00F) return 12'h222;
`endif
        return v.exp_rgb;
    endfunction

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        draw_x = v.x; draw_y = v.y; i_rgb = v.rgb;
        blkpos_x = v.bx; blkpos_y = v.by; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        checkOutput($sformatf("vec%0d map_addr", idx), 32'(map_addr), 32'(v.exp_addr));
        @(negedge clk);
        checkOutput($sformatf("vec%0d o_valid early", idx), 32'(o_valid), 32'd0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d o_valid", idx), 32'(o_valid), 32'd1);
        checkOutput($sformatf("vec%0d o_rgb", idx), 32'(o_rgb), 32'(expRgb(v)));
        checkOutput($sformatf("vec%0d o_in_map", idx), 32'(o_in_map), 32'(v.exp_in_map));
    endtask

    initial begin
        vec_t vecs [15];
        logic exp_phase [5];

        for (int i = 0; i < 256; i++) mem[i] = 4'd0;
        mem[0] = 4'd1;  mem[1] = 4'd1;  mem[2] = 4'd0;   mem[3] = 4'd3;
        mem[5] = 4'd9;  mem[20] = 4'd2; mem[197] = 4'd0; mem[208] = 4'd2;

        //          x     y     rgb      bx     by    addr  exp rgb  in    grid
        vecs[0]  = '{11'd32,   10'd48,  12'h111, 11'd1500, 10'd900,  8'd0,   12'h888, 1'b1, 1'b1};
        vecs[1]  = '{11'd1247, 10'd751, 12'h111, 11'd1500, 10'd900,  8'd208, 12'hA52, 1'b1, 1'b0};
        vecs[2]  = '{11'd31,   10'd48,  12'hF2F, 11'd1500, 10'd900,  8'd0,   12'hF2F, 1'b0, 1'b0};
        vecs[3]  = '{11'd1248, 10'd100, 12'hF2F, 11'd1500, 10'd900,  8'd0,   12'hF2F, 1'b0, 1'b0};
        vecs[4]  = '{11'd500,  10'd752, 12'h3C3, 11'd1500, 10'd900,  8'd0,   12'h3C3, 1'b0, 1'b0};
        vecs[5]  = '{11'd500,  10'd751, 12'h456, 11'd1500, 10'd900,  8'd197, 12'h456, 1'b1, 1'b0};
        vecs[6]  = '{11'd360,  10'd60,  12'h777, 11'd1500, 10'd900,  8'd5,   12'hF0F, 1'b1, 1'b0};
        vecs[7]  = '{11'd170,  10'd100, 12'h123, 11'd1500, 10'd900,  8'd2,   12'h123, 1'b1, 1'b0};
        vecs[8]  = '{11'd230,  10'd60,  12'h123, 11'd1500, 10'd900,  8'd3,   12'h000, 1'b1, 1'b0};
        vecs[9]  = '{11'd100,  10'd100, 12'h123, 11'd100,  10'd100,  8'd1,   12'h00F, 1'b1, 1'b0};
        vecs[10] = '{11'd147,  10'd147, 12'h123, 11'd100,  10'd100,  8'd20,  12'h00F, 1'b1, 1'b0};
        vecs[11] = '{11'd148,  10'd147, 12'h123, 11'd100,  10'd100,  8'd20,  12'hA52, 1'b1, 1'b0};
        vecs[12] = '{11'd147,  10'd148, 12'h123, 11'd100,  10'd100,  8'd20,  12'hA52, 1'b1, 1'b0};
        vecs[13] = '{11'd2045, 10'd1010,12'h5A5, 11'd2040, 10'd1000, 8'd0,   12'h00F, 1'b0, 1'b0};
        vecs[14] = '{11'd10,   10'd10,  12'h5A5, 11'd0,    10'd0,    8'd0,   12'h00F, 1'b0, 1'b0};

        exp_phase = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset held while i_valid toggles: every output must stay cleared
        draw_x = 11'd40; draw_y = 10'd56; i_rgb = 12'h111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("reset o_valid", 32'(o_valid), 32'd0);
            checkOutput("reset o_rgb", 32'(o_rgb), 32'd0);
            checkOutput("reset map_addr", 32'(map_addr), 32'd0);
            i_valid = (i % 2 == 0);
        end
        @(negedge clk);
        checkOutput("reset o_valid", 32'(o_valid), 32'd0);
        rst_n = 1'b1; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        checkOutput("first pixel o_valid +1", 32'(o_valid), 32'd0);
        @(negedge clk);
        checkOutput("first pixel o_valid +2", 32'(o_valid), 32'd0);
        @(negedge clk);
        checkOutput("first pixel o_valid +3", 32'(o_valid), 32'd1);
        checkOutput("first pixel o_rgb", 32'(o_rgb), 32'h888);

        // Directed vector table
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

        // Streaming with random gaps and an async reset pulse partway through
        blkpos_x = 11'd1500; blkpos_y = 10'd900;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checkOutput("stream o_valid", 32'(o_valid), 32'(hist[2]));
            if (i == 150) begin
                rst_n = 1'b0; i_valid = 1'b0;
                #1;
                checkOutput("async reset o_valid", 32'(o_valid), 32'd0);
                checkOutput("async reset o_rgb", 32'(o_rgb), 32'd0);
            end else begin
                rst_n = 1'b1;
                i_valid = 1'($urandom_range(0, 1));
                draw_x = 11'($urandom_range(1, 1400));
                draw_y = 10'($urandom_range(0, 800));
                i_rgb = 12'($urandom_range(0, 4095));
            end
        end
        @(negedge clk);
        i_valid = 1'b0;

        // Bomb blink: after each frame start, the very next pixel already sees the new phase
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 5; f++) begin
            if (f > 0) begin
                @(negedge clk);
                draw_x = 11'd0; draw_y = 10'd0; i_rgb = 12'h0AB; i_valid = 1'b1;
            end
            @(negedge clk);
            draw_x = 11'd230; draw_y = 10'd60; i_rgb = 12'h123; i_valid = 1'b1;
            @(negedge clk);
            i_valid = 1'b0;
            @(negedge clk);
            if (f > 0) begin
                checkOutput($sformatf("frame%0d start pixel o_rgb", f), 32'(o_rgb), 32'h0AB);
                checkOutput($sformatf("frame%0d start pixel o_in_map", f), 32'(o_in_map), 32'd0);
            end
            @(negedge clk);
            checkOutput($sformatf("frame%0d bomb o_valid", f), 32'(o_valid), 32'd1);
            checkOutput($sformatf("frame%0d bomb o_rgb", f), 32'(o_rgb),
                        exp_phase[f] ? 32'hF00 : 32'h000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tile_renderer.md
Name: tile_renderer

Overview:
- Parametrised, pipelined successor to the current map draw path for the Bomberman screen.
- Converts the raster position (draw_x, draw_y) into a tile-map read address and reads the tile state from a synchronous map memory (tile_map_mem, 1-cycle read).
- Maps each tile state through a fixed palette and overlays the player box.
- Produces registered RGB aligned to a valid strobe at fixed latency 3.
- Adds over the current block: configurable map geometry and origin, a valid-tracked pipeline, and a frame-counted blinking bomb state.

Parameters:
- NUM_COL, 19, map columns
- NUM_ROW, 11, map rows
- DATA_WIDTH, 4, tile state width
- TILE_SHIFT, 6, log2 of tile size in pixels (square tiles, 64 px)
- MAP_X0, 32, pixel x of map left edge
- MAP_Y0, 48, pixel y of map top edge
- PLAYER_SIZE, 48, player box side in pixels
- BLINK_FRAMES, 16, frames per bomb blink phase (>=1)
- ADDR_W, $clog2(NUM_ROW*NUM_COL), map address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  draw_x/draw_y/i_rgb valid this cycle
- draw_x  in  11  raster x
- draw_y  in  10  raster y
- i_rgb  in  12  background colour {r,g,b}
- blkpos_x  in  11  player top-left x
- blkpos_y  in  10  player top-left y
- map_addr  out  ADDR_W  map memory read address
- map_rd_data  in  DATA_WIDTH  map memory data, valid 1 cycle after map_addr
- o_valid  out  1  output pixel valid
- o_rgb  out  12  output colour
- o_in_map  out  1  output pixel lies inside map area

Behaviour:
- Reset (async, rst_n=0): map_addr=0, o_valid=0, o_rgb=0, o_in_map=0; all pipeline valids, frame counter and blink_phase cleared. Reset mid-stream drops all in-flight pixels. The first o_valid occurs 3 cycles after the first i_valid following release.
- S1 (cycle after sampling):
  - in_map = (MAP_X0 <= draw_x < MAP_X0 + NUM_COL<<TILE_SHIFT) and the same test for y with MAP_Y0, NUM_ROW.
  - col = (draw_x-MAP_X0)>>TILE_SHIFT; row = (draw_y-MAP_Y0)>>TILE_SHIFT.
  - map_addr <= row*NUM_COL+col when in_map, else 0. map_addr updates only on i_valid; otherwise it holds.
  - player_hit = blkpos_x <= draw_x < blkpos_x+PLAYER_SIZE and the same test for y, computed at full width with no wrap. in_map, player_hit, i_rgb and valid are registered.
- S2: map_rd_data is captured with the S2 sideband.
- S3 (output register), colour priority:
  1. player_hit: 12'h00F
  2. !in_map: i_rgb
  3. state 0: i_rgb
  4. state 1 (hard wall): 12'h888
  5. state 2 (soft block): 12'hA52
  6. state 3 (bomb): blink_phase ? 12'hF00 : 12'h000
  7. any other state: 12'hF0F
- Latency: exactly 3 clocks from i_valid to o_valid, independent of gaps. Bubbles propagate; stages do not stall, and there is no backpressure.
- Frame start is a valid input with draw_x==0 and draw_y==0.
  - On frame start: frame_cnt==BLINK_FRAMES-1 ? (frame_cnt<=0, blink_phase toggles) : frame_cnt+1.
  - The new phase applies to pixels sampled after the frame-start pixel.
- Boundaries: x = MAP_X0+NUM_COL*64-1 is in the map; x one greater is not. Last tile address = NUM_ROW*NUM_COL-1 (208 by default). Player box partially outside the map still overlays.

Optional Feature:
- GRID_LINES_EN defined: in-map pixels whose local x or y offset within the tile is 0 output 12'h222, below player priority and above tile colour. Local offsets are pipelined with the sideband.
- Undefined: no grid; logic absent.

Test Plan:
- Reset: hold rst_n=0 with i_valid toggling -> o_valid=0, o_rgb=0, map_addr=0. Release rst_n, drive a pixel -> first o_valid exactly 3 cycles later.
- Tile lookup: map[0]=1, pixel (32,48) -> map_addr=0 one cycle later, o_rgb=888, o_in_map=1. Map[208]=2, pixel (1247,751) -> map_addr=208, o_rgb=A52.
- Outside map: pixel (31,48) and (1248,100) with i_rgb=F2F -> o_rgb=F2F, o_in_map=0. Unknown state 9 in map -> F0F.
- Player overlay: blkpos=(100,100), pixels (100,100) and (147,147) -> 00F; pixel (148,147) -> tile/background colour.
- Blink: bomb tile, BLINK_FRAMES=2 -> o_rgb 000 for frames 0-1 and F00 for frames 2-3 across 4 raster frame starts.
- Streaming: full raster with random i_valid gaps -> o_valid equals i_valid delayed 3 cycles. Async reset pulse mid-line -> o_valid=0 next edge, no stale pixels afterward.
